// File: rtl/usb_line_pkg.sv
// Shared definitions for the USB full-speed line monitor: line-state
// encodings, the bus-condition FSM states and the 60 MHz default cycle counts.
package usb_line_pkg;

  // Synchronised line state is {D+, D-}
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  // 2.5 us of SE0 declares bus reset, 3 ms of idle J declares suspend
  localparam int unsigned DEFAULT_RESET_CYCLES   = 150;
  localparam int unsigned DEFAULT_SUSPEND_CYCLES = 180000;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_SE0_WAIT  = 2'd1,
    ST_BUS_RESET = 2'd2,
    ST_SUSPENDED = 2'd3
  } line_fsm_e;

  function automatic logic is_se0(input logic [1:0] ls);
    return ls == LINE_SE0;
  endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Two-flop synchroniser for the raw {D+, D-} receive pins. Both stages come
// out of reset holding J so the monitor sees an idle bus until real samples
// have propagated through.
module usb_line_sync
  import usb_line_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] async_i,
  output logic [1:0] sync_o
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] meta_q;
  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

  // Capture the asynchronous pins, then resample once to settle metastability
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= LINE_J;
      sync_q <= LINE_J;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/usb_line_monitor.sv
// Classifies the full-speed USB bus condition for the bootloader: bus reset
// (sustained SE0), suspend (sustained idle J) and resume (K while suspended).
// Runs entirely in the 60 MHz USB clock domain; every output is a flop.
module usb_line_monitor
  import usb_line_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = DEFAULT_RESET_CYCLES,
  parameter int unsigned SUSPEND_CYCLES = DEFAULT_SUSPEND_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       usb_reset,
  output logic       suspend,
  output logic       resume
);

  localparam int unsigned SE0_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(SUSPEND_CYCLES + 1);

  localparam logic [SE0_W-1:0]  SE0_LIMIT  = SE0_W'(RESET_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(SUSPEND_CYCLES);
  localparam logic [SE0_W-1:0]  SE0_ONE    = SE0_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

  logic [1:0]        line_sync;
  line_fsm_e         state_q, state_d;
  logic [SE0_W-1:0]  se0_cnt_q, se0_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [SE0_W-1:0]  se0_inc;
  logic [IDLE_W-1:0] idle_inc;
  logic              usb_reset_q, usb_reset_d;
  logic              suspend_q, suspend_d;
  logic              resume_q, resume_d;

  usb_line_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({usb_p_rx, usb_n_rx}),
    .sync_o  (line_sync)
  );

  // se0_cnt is always below the limit while it is still counting, so the
  // increment cannot overflow; idle_cnt holds at its limit instead of wrapping
  assign se0_inc  = se0_cnt_q + SE0_ONE;
  assign idle_inc = (idle_cnt_q == IDLE_LIMIT) ? idle_cnt_q : idle_cnt_q + IDLE_ONE;

  // State, counters and registered outputs all update together
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACTIVE;
      se0_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      usb_reset_q <= 1'b0;
      suspend_q   <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      se0_cnt_q   <= se0_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      usb_reset_q <= usb_reset_d;
      suspend_q   <= suspend_d;
      resume_q    <= resume_d;
    end
  end

  // Next state and counters; a threshold only fires on a sample that still
  // shows the line condition being timed
  always_comb begin
    state_d    = state_q;
    se0_cnt_d  = se0_cnt_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        case (line_sync)
          LINE_J: begin
            idle_cnt_d = idle_inc;
            if (idle_inc == IDLE_LIMIT) begin
              state_d = ST_SUSPENDED;
            end
          end
          LINE_SE0: begin
            idle_cnt_d = '0;
            se0_cnt_d  = SE0_ONE;
            state_d    = ST_SE0_WAIT;
          end
          default: begin
            idle_cnt_d = '0;
          end
        endcase
      end
      ST_SE0_WAIT: begin
        if (is_se0(line_sync)) begin
          se0_cnt_d = se0_inc;
          if (se0_inc == SE0_LIMIT) begin
            state_d = ST_BUS_RESET;
          end
        end else begin
          se0_cnt_d = '0;
          state_d   = ST_ACTIVE;
        end
      end
      ST_BUS_RESET: begin
        if (!is_se0(line_sync)) begin
          se0_cnt_d  = '0;
          idle_cnt_d = '0;
          state_d    = ST_ACTIVE;
        end
      end
      ST_SUSPENDED: begin
        case (line_sync)
          LINE_K: begin
            idle_cnt_d = '0;
            state_d    = ST_ACTIVE;
          end
          LINE_SE0: begin
            idle_cnt_d = '0;
            se0_cnt_d  = SE0_ONE;
            state_d    = ST_SE0_WAIT;
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // Output decode from the upcoming state; a reset-from-suspend keeps
  // suspend asserted through SE0_WAIT until BUS_RESET takes over
  always_comb begin
    usb_reset_d = (state_d == ST_BUS_RESET);
    suspend_d   = 1'b0;
    if (state_d == ST_SUSPENDED) begin
      suspend_d = 1'b1;
    end else if (state_d == ST_SE0_WAIT) begin
      suspend_d = suspend_q || (state_q == ST_SUSPENDED);
    end
    resume_d = (state_q == ST_SUSPENDED) && (line_sync == LINE_K);
  end

  assign line_state = line_sync;
  assign usb_reset  = usb_reset_q;
  assign suspend    = suspend_q;
  assign resume     = resume_q;

endmodule
